ov9281_cfg_seq: RTL

Power-up configuration sequencer for the OV9281 SCCB/I2C write engine. It walks a register table held in an external synchronous ROM. For each entry it presents a 32-bit word to the write engine, pulses a transfer, checks the ack result and retries on NACK. It signals completion to the rest of the camera pipeline and runs entirely in the clock_i2c domain.

---
 rtl/ov9281_cfg_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ov9281_cfg_seq.sv
// OV9281 power-up configuration sequencer: walks the register ROM and feeds the SCCB write engine, with NACK retry.
// Build option CFG_DELAY_CMD_EN: ROM words whose top byte is 8'hFF become inline delay commands.

module ov9281_cfg_seq #(
    parameter int REG_NUM      = 64,
    parameter int IDX_W        = 8,
    parameter int PWR_WAIT_CYC = 400,
    parameter int GAP_CYC      = 4,
    parameter int MAX_RETRY    = 3,
    parameter int TIMEOUT_CYC  = 80
) (
    input  logic             clock_i2c,
    input  logic             camera_rstn,
    input  logic             reinit,
    output logic [IDX_W-1:0] lut_index,
    input  logic [31:0]      lut_data,
    output logic [31:0]      i2c_data,
    output logic             start,
    input  logic             tr_end,
    input  logic             ack,
    output logic             busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [7:0]       err_count
);

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_LOAD,
        S_XFER,
        S_EVAL,
        S_GAP,
`ifdef CFG_DELAY_CMD_EN
        S_DELAY,
`endif
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        data_q, data_d;
    logic [7:0]         retry_q, retry_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [7:0]         errcnt_q, errcnt_d;
`ifdef CFG_DELAY_CMD_EN
    logic [15:0]        dly_q, dly_d;
`endif

    always_ff @(posedge clock_i2c or negedge camera_rstn) begin
        if (!camera_rstn) begin
            state_q  <= S_PWR_WAIT;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            retry_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
`ifdef CFG_DELAY_CMD_EN
            dly_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            retry_q  <= retry_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
`ifdef CFG_DELAY_CMD_EN
            dly_q    <= dly_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        retry_d  = retry_q;
        ack_d    = ack_q;
        err_d    = err_q;
        errcnt_d = errcnt_q;
`ifdef CFG_DELAY_CMD_EN
        dly_d    = dly_q;
`endif
        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q == 32'(PWR_WAIT_CYC - 1)) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            // ROM word is valid one cycle after the index settles; sample on the second cycle
            S_LOAD: begin
                if (cnt_q == 32'd1) begin
                    cnt_d = '0;
`ifdef CFG_DELAY_CMD_EN
                    if (lut_data[31:24] == 8'hFF) begin
                        state_d = S_DELAY;
                        dly_d   = (lut_data[15:0] == 16'd0) ? 16'd1 : lut_data[15:0];
                    end else begin
                        state_d = S_XFER;
                        data_d  = lut_data;
                    end
`else
                    state_d = S_XFER;
                    data_d  = lut_data;
`endif
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_XFER: begin
                if (tr_end) begin
                    ack_d   = ack;
                    state_d = S_EVAL;
                    cnt_d   = '0;
                end else if (cnt_q == 32'(TIMEOUT_CYC - 1)) begin
                    ack_d   = 1'b1;
                    state_d = S_EVAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_EVAL: begin
                if (!ack_q) begin
                    retry_d = '0;
                    idx_d   = idx_q + IDX_W'(1);
                end else if (retry_q < 8'(MAX_RETRY)) begin
                    retry_d = retry_q + 8'd1;
                end else begin
                    err_d    = 1'b1;
                    errcnt_d = (errcnt_q == 8'hFF) ? errcnt_q : errcnt_q + 8'd1;
                    retry_d  = '0;
                    idx_d    = idx_q + IDX_W'(1);
                end
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt_q == 32'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = (idx_q == IDX_W'(REG_NUM)) ? S_DONE : S_LOAD;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
`ifdef CFG_DELAY_CMD_EN
            S_DELAY: begin
                if (cnt_q == {16'd0, dly_q} - 32'd1) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
`endif
            S_DONE: begin
                cnt_d = '0;
            end
            default: begin
                state_d = S_PWR_WAIT;
                cnt_d   = '0;
            end
        endcase

        // reinit aborts anything in flight, including an active transfer
        if (reinit) begin
            state_d  = S_PWR_WAIT;
            cnt_d    = '0;
            idx_d    = '0;
            retry_d  = '0;
            err_d    = 1'b0;
            errcnt_d = '0;
        end
    end

    always_comb begin
        start     = (state_q == S_XFER);
        busy      = (state_q != S_DONE);
        cfg_done  = (state_q == S_DONE);
        lut_index = idx_q;
        i2c_data  = data_q;
        cfg_err   = err_q;
        err_count = errcnt_q;
    end

endmodule
